neuron_seq_mac: RTL and testbench

Time-multiplexed successor to the fully parallel neuron.
- Computes one fixed-point dot product plus bias over NUM_INPUTS inputs, using a single multiplier that is reused for NUM_INPUTS cycles.
- Weights and bias are held in an internal register file, loaded one word per cycle by index.
- The result is saturated to OUT_SIZE, an optional ReLU is applied, and it is returned through a valid/ready handshake.
- Sits between the TDNN tap-delay line (source of NEURON_IN) and the next layer.

---
 rtl/neuron_seq_mac.sv | 125 ++++++++++++
 tb/tb_neuron_seq_mac.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_mac.sv
// neuron_seq_mac: time-multiplexed fixed-point neuron, one multiplier reused per input,
// weight/bias register file, saturating output with optional ReLU and valid/ready handshake.
module neuron_seq_mac #(
    parameter int SIG_SIZE    = 16,
    parameter int WEIGHT_SIZE = 16,
    parameter int NUM_INPUTS  = 8,
    parameter int FRAC_BITS   = 15,
    parameter int ACC_SIZE    = 24,
    parameter int OUT_SIZE    = 16
) (
    input  logic                               CLOCK_N,
    input  logic                               RESET,
    input  logic                               WB_EN,
    input  logic [$clog2(NUM_INPUTS+1)-1:0]    WB_ADDR,
    input  logic [WEIGHT_SIZE-1:0]             WB_DATA,
    input  logic                               START,
    input  logic [NUM_INPUTS*SIG_SIZE-1:0]     NEURON_IN,
    input  logic                               ACT_MODE,
    input  logic                               OUT_READY,
    output logic                               BUSY,
    output logic                               OUT_VALID,
    output logic [OUT_SIZE-1:0]                NEURON_OUT,
    output logic                               SAT_FLAG
);
    localparam int AW = $clog2(NUM_INPUTS + 1);
    localparam int PW = SIG_SIZE + WEIGHT_SIZE;
    localparam logic signed [ACC_SIZE-1:0] OMAX = {{(ACC_SIZE-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, FINISH, DONE} state_t;

    state_t                         state_q, state_d;
    logic signed [WEIGHT_SIZE-1:0]  w_q [NUM_INPUTS+1];
    logic signed [WEIGHT_SIZE-1:0]  w_d [NUM_INPUTS+1];
    logic [NUM_INPUTS*SIG_SIZE-1:0] in_q, in_d;
    logic                           relu_q, relu_d;
    logic signed [ACC_SIZE-1:0]     acc_q, acc_d;
    logic [AW-1:0]                  k_q, k_d;
    logic [OUT_SIZE-1:0]            out_q, out_d;
    logic                           valid_q, valid_d;
    logic                           sat_q, sat_d;
    logic signed [PW-1:0]           prod, shifted;
    logic signed [ACC_SIZE-1:0]     term;
    logic [OUT_SIZE-1:0]            clamped;
    logic                           hi, lo;

    // Inputs are consumed from a shift register, so the current tap is always the low word.
    always_comb begin
        prod    = $signed(in_q[SIG_SIZE-1:0]) * w_q[k_q];
        shifted = prod >>> FRAC_BITS;
        term    = ACC_SIZE'(shifted);
        hi      = acc_q > OMAX;
        lo      = acc_q < OMIN;
        clamped = hi ? OMAX[OUT_SIZE-1:0] : lo ? OMIN[OUT_SIZE-1:0] : acc_q[OUT_SIZE-1:0];
        state_d = state_q;
        w_d     = w_q;
        in_d    = in_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        k_d     = k_q;
        out_d   = out_q;
        valid_d = valid_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (WB_EN && WB_ADDR <= AW'(NUM_INPUTS))
                    w_d[WB_ADDR] = WB_DATA;
                if (START) begin
                    state_d = MAC;
                    in_d    = NEURON_IN;
                    relu_d  = ACT_MODE;
                    acc_d   = ACC_SIZE'(w_d[NUM_INPUTS]);
                    k_d     = '0;
                end
            end
            MAC: begin
                acc_d   = acc_q + term;
                k_d     = k_q + 1'b1;
                in_d    = in_q >> SIG_SIZE;
                state_d = (k_q == AW'(NUM_INPUTS - 1)) ? FINISH : MAC;
            end
            FINISH: begin
                out_d   = (relu_q && clamped[OUT_SIZE-1]) ? '0 : clamped;
                sat_d   = hi | lo;
                valid_d = 1'b1;
                state_d = DONE;
            end
            default: begin
                if (OUT_READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(negedge CLOCK_N or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            w_q     <= '{default: '0};
            in_q    <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            in_q    <= in_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign BUSY       = state_q != IDLE;
    assign OUT_VALID  = valid_q;
    assign NEURON_OUT = out_q;
    assign SAT_FLAG   = sat_q;
endmodule

// File: tb/tb_neuron_seq_mac.sv
// tb_neuron_seq_mac: directed tests for neuron_seq_mac with NUM_INPUTS=3, Q1.15.
module tb_neuron_seq_mac;
    localparam int N  = 3;
    localparam int AW = 2;

    logic          clk = 1'b1;
    logic          RESET = 1'b1;
    logic          WB_EN = 1'b0;
    logic [AW-1:0] WB_ADDR = '0;
    logic [15:0]   WB_DATA = '0;
    logic          START = 1'b0;
    logic [47:0]   NEURON_IN = '0;
    logic          ACT_MODE = 1'b0;
    logic          OUT_READY = 1'b1;
    logic          BUSY, OUT_VALID, SAT_FLAG;
    logic [15:0]   NEURON_OUT;
    int            passed = 0;
    int            total = 0;

    neuron_seq_mac #(.SIG_SIZE(16), .WEIGHT_SIZE(16), .NUM_INPUTS(N), .FRAC_BITS(15),
                     .ACC_SIZE(24), .OUT_SIZE(16)) dut (
        .CLOCK_N(clk), .RESET(RESET), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .START(START), .NEURON_IN(NEURON_IN), .ACT_MODE(ACT_MODE), .OUT_READY(OUT_READY),
        .BUSY(BUSY), .OUT_VALID(OUT_VALID), .NEURON_OUT(NEURON_OUT), .SAT_FLAG(SAT_FLAG)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        WB_EN = 1'b1;
        WB_ADDR = AW'(a);
        WB_DATA = d;
        tick();
        WB_EN = 1'b0;
    endtask

    task automatic load(input logic [15:0] w0, w1, w2, b);
        wr(0, w0);
        wr(1, w1);
        wr(2, w2);
        wr(3, b);
    endtask

    // Returns the number of edges from the START edge until OUT_VALID is seen (20 = timeout).
    task automatic run(input logic [15:0] x0, x1, x2, input logic act, output int lat);
        NEURON_IN = {x2, x1, x0};
        ACT_MODE = act;
        START = 1'b1;
        tick();
        START = 1'b0;
        NEURON_IN = {16'($urandom), 16'($urandom), 16'($urandom)};
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({BUSY, OUT_VALID, NEURON_OUT, SAT_FLAG} !== 19'd0)
            $display("FAIL reset: got %h expected 0", {BUSY, OUT_VALID, NEURON_OUT, SAT_FLAG});
        else passed++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        load(16'h4000, 16'h4000, 16'h4000, 16'h0000);
        run(16'h4000, 16'h4000, 16'h4000, 1'b0, lat);
        total++;
        if (lat !== N + 1) $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1);
        else passed++;
        total++;
        if (NEURON_OUT !== 16'h6000) $display("FAIL basic_out: got %h expected 6000", NEURON_OUT);
        else passed++;
        total++;
        if ({BUSY, SAT_FLAG} !== 2'b10) $display("FAIL basic_busy_sat: got %b expected 10", {BUSY, SAT_FLAG});
        else passed++;
        tick();
        total++;
        if ({BUSY, OUT_VALID} !== 2'b00) $display("FAIL basic_handshake: got %b expected 00", {BUSY, OUT_VALID});
        else passed++;
        total++;
        if (NEURON_OUT !== 16'h6000) $display("FAIL basic_hold: got %h expected 6000", NEURON_OUT);
        else passed++;
    endtask

    task automatic test_pos_sat();
        int lat;
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, lat);
        total++;
        if ({SAT_FLAG, NEURON_OUT} !== {1'b1, 16'h7FFF})
            $display("FAIL pos_sat: got sat=%b out=%h expected sat=1 out=7fff", SAT_FLAG, NEURON_OUT);
        else passed++;
        tick();
    endtask

    task automatic test_neg_sat_relu();
        int lat;
        load(16'h8000, 16'h8000, 16'h8000, 16'h0000);
        run(16'h4000, 16'h4000, 16'h4000, 1'b0, lat);
        total++;
        if ({SAT_FLAG, NEURON_OUT} !== {1'b1, 16'h8000})
            $display("FAIL neg_sat: got sat=%b out=%h expected sat=1 out=8000", SAT_FLAG, NEURON_OUT);
        else passed++;
        tick();
        run(16'h4000, 16'h4000, 16'h4000, 1'b1, lat);
        total++;
        if ({SAT_FLAG, NEURON_OUT} !== {1'b1, 16'h0000})
            $display("FAIL neg_sat_relu: got sat=%b out=%h expected sat=1 out=0000", SAT_FLAG, NEURON_OUT);
        else passed++;
        tick();
    endtask

    task automatic test_floor();
        int lat;
        load(16'h0001, 16'h0000, 16'h0000, 16'h0005);
        run(16'hFFFF, 16'h0000, 16'h0000, 1'b0, lat);
        total++;
        if ({SAT_FLAG, NEURON_OUT} !== {1'b0, 16'h0004})
            $display("FAIL floor: got sat=%b out=%h expected sat=0 out=0004", SAT_FLAG, NEURON_OUT);
        else passed++;
        tick();
    endtask

    task automatic test_write_with_start();
        int lat;
        load(16'h4000, 16'h4000, 16'h4000, 16'h0000);
        WB_EN = 1'b1;
        WB_ADDR = 2'd3;
        WB_DATA = 16'h0100;
        NEURON_IN = {16'h4000, 16'h4000, 16'h4000};
        START = 1'b1;
        tick();
        WB_EN = 1'b0;
        START = 1'b0;
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (NEURON_OUT !== 16'h6100) $display("FAIL write_with_start: got %h expected 6100", NEURON_OUT);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back_backpressure();
        int lat;
        load(16'h4000, 16'h4000, 16'h4000, 16'h0000);
        OUT_READY = 1'b0;
        NEURON_IN = {16'h4000, 16'h4000, 16'h4000};
        START = 1'b1;
        tick();
        NEURON_IN = {16'h7FFF, 16'h7FFF, 16'h7FFF};
        WB_EN = 1'b1;
        WB_ADDR = 2'd0;
        WB_DATA = 16'h7FFF;
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== N + 1) $display("FAIL bp_latency: got %0d expected %0d", lat, N + 1);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            WB_ADDR = AW'(i % 4);
            tick();
            total++;
            if ({BUSY, OUT_VALID, NEURON_OUT} !== {2'b11, 16'h6000})
                $display("FAIL bp_hold[%0d]: got busy=%b valid=%b out=%h expected 1 1 6000", i, BUSY, OUT_VALID, NEURON_OUT);
            else passed++;
        end
        WB_EN = 1'b0;
        START = 1'b0;
        OUT_READY = 1'b1;
        tick();
        total++;
        if ({BUSY, OUT_VALID} !== 2'b00) $display("FAIL bp_release: got %b expected 00", {BUSY, OUT_VALID});
        else passed++;
        tick();
        total++;
        if (BUSY !== 1'b0) $display("FAIL bp_no_second_eval: got busy=%b expected 0", BUSY);
        else passed++;
        run(16'h4000, 16'h4000, 16'h4000, 1'b0, lat);
        total++;
        if (NEURON_OUT !== 16'h6000) $display("FAIL bp_rerun: got %h expected 6000", NEURON_OUT);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_mac();
        int lat;
        load(16'h4000, 16'h4000, 16'h4000, 16'h1234);
        NEURON_IN = {16'h4000, 16'h4000, 16'h4000};
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
        total++;
        if ({BUSY, OUT_VALID, NEURON_OUT} !== 18'd0)
            $display("FAIL reset_mid_mac: got busy=%b valid=%b out=%h expected 0 0 0000", BUSY, OUT_VALID, NEURON_OUT);
        else passed++;
        tick();
        RESET = 1'b0;
        tick();
        run(16'h4000, 16'h4000, 16'h4000, 1'b0, lat);
        total++;
        if (lat !== N + 1) $display("FAIL post_reset_latency: got %0d expected %0d", lat, N + 1);
        else passed++;
        total++;
        if ({SAT_FLAG, NEURON_OUT} !== 17'd0)
            $display("FAIL post_reset_out: got sat=%b out=%h expected sat=0 out=0000", SAT_FLAG, NEURON_OUT);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat_relu();
        test_floor();
        test_write_with_start();
        test_back_to_back_backpressure();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
